wh_output_scheduler: RTL and testbench

// Per-output-port wormhole scheduler for the mesh router switch stage. One instance sits
// in front of each output port (L/N/E/W). It chooses one input between NREQ competing

---
 rtl/wh_output_scheduler_if.sv | 28 ++
 rtl/wh_output_scheduler.sv | 138 +++++++++++++
 tb/tb_wh_output_scheduler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/wh_output_scheduler_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wh_output_scheduler_if : request/grant bundle of an output port  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface wh_output_scheduler_if #(
  parameter int NREQ = 4
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] flit_type;
  logic              credit_inc;
  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     grant_idx;
  logic              out_valid;

  modport master (
    output req, flit_type, credit_inc,
    input  grant, grant_idx, out_valid
  );

  modport slave (
    input  req, flit_type, credit_inc,
    output grant, grant_idx, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/wh_output_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wh_output_scheduler : round-robin wormhole arbiter with credits  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module wh_output_scheduler #(
  parameter int NREQ    = 4,
  parameter int CREDITS = 8,
  parameter int CW      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  wh_output_scheduler_if.slave     bus,
  output logic                     locked,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic [CW-1:0]            credit_cnt,
  output logic                     credit_err
);
  localparam int             IW        = $clog2(NREQ);
  localparam logic [1:0]     FT_HEAD   = 2'b00;
  localparam logic [1:0]     FT_TAIL   = 2'b10;
  localparam logic [1:0]     FT_SINGLE = 2'b11;
  localparam logic [CW-1:0]  CRED_MAX  = CW'(CREDITS);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   credit_cnt_q, credit_cnt_d;
  logic            credit_err_q, credit_err_d;

  logic [IW-1:0]   cand, win, gnt_idx;
  logic            found;
  logic [NREQ-1:0] gnt;
  logic [1:0]      sel_ft;

  function automatic logic [1:0] ft_of(input logic [2*NREQ-1:0] ft, input logic [IW-1:0] i);
    return ft[2*i +: 2];
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NREQ-1)) ? '0 : i + 1'b1;
  endfunction

  // Idle candidates may only open a packet: head or single flits.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && bus.req[cand] &&
          (ft_of(bus.flit_type, cand) == FT_HEAD || ft_of(bus.flit_type, cand) == FT_SINGLE)) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Gated by rst_n so nothing leaves the port while reset is held.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    sel_ft  = FT_HEAD;
    if (rst_n && credit_cnt_q != '0) begin
      if (state_q == ST_IDLE) begin
        if (found) begin
          gnt[win] = 1'b1;
          gnt_idx  = win;
          sel_ft   = ft_of(bus.flit_type, win);
        end
      end else if (bus.req[owner_q]) begin
        gnt[owner_q] = 1'b1;
        gnt_idx      = owner_q;
        sel_ft       = ft_of(bus.flit_type, owner_q);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (|gnt) begin
      if (state_q == ST_IDLE) begin
        rr_ptr_d = next_idx(gnt_idx);
        if (sel_ft == FT_HEAD) begin
          state_d = ST_LOCKED;
          owner_d = gnt_idx;
        end
      end else if (sel_ft == FT_TAIL || sel_ft == FT_SINGLE) begin
        state_d  = ST_IDLE;
        rr_ptr_d = next_idx(owner_q);
      end
    end
  end

  // A simultaneous free and consume cancel out, even at a full counter.
  always_comb begin
    credit_cnt_d = credit_cnt_q;
    credit_err_d = credit_err_q;
    case ({bus.credit_inc, |gnt})
      2'b01:   credit_cnt_d = credit_cnt_q - 1'b1;
      2'b10: begin
        if (credit_cnt_q == CRED_MAX) credit_err_d = 1'b1;
        else                          credit_cnt_d = credit_cnt_q + 1'b1;
      end
      default: credit_cnt_d = credit_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      credit_cnt_q <= CRED_MAX;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      credit_cnt_q <= credit_cnt_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign bus.grant     = gnt;
  assign bus.grant_idx = gnt_idx;
  assign bus.out_valid = |gnt;
  assign locked        = (state_q == ST_LOCKED);
  assign owner         = owner_q;
  assign credit_cnt    = credit_cnt_q;
  assign credit_err    = credit_err_q;

endmodule
`default_nettype wire

// File: tb/tb_wh_output_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_wh_output_scheduler : directed bench for wh_output_scheduler  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_wh_output_scheduler;
  logic       clk;
  logic       rst_n;
  logic       locked;
  logic [1:0] owner;
  logic [3:0] credit_cnt;
  logic       credit_err;

  int n_checks = 0;
  int n_fail   = 0;

  wh_output_scheduler_if #(.NREQ(4)) bus_if ();

  wh_output_scheduler #(.NREQ(4), .CREDITS(8), .CW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if.slave),
    .locked     (locked),
    .owner      (owner),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_rr [0:4];
  logic [3:0] exp_t4 [0:7];

  initial begin
    exp_rr = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    exp_t4 = '{4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4};

    // T1 reset with everyone requesting
    rst_n             = 1'b0;
    bus_if.req        = 4'hF;
    bus_if.flit_type  = 8'hFF;
    bus_if.credit_inc = 1'b0;
    tick();
    tick();
    check("t1_grant",      32'(bus_if.grant), 32'h0);
    check("t1_out_valid",  32'(bus_if.out_valid), 32'h0);
    check("t1_credit_cnt", 32'(credit_cnt), 32'd8);
    check("t1_locked",     32'(locked), 32'h0);
    check("t1_credit_err", 32'(credit_err), 32'h0);
    rst_n = 1'b1;
    #1;

    // T2 round robin of single flits, credits refilled each cycle
    bus_if.credit_inc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t2_grant", 32'(bus_if.grant), 32'(exp_rr[i]));
      check("t2_grant_idx", 32'(bus_if.grant_idx), 32'(i % 4));
      tick();
    end
    check("t2_credit_cnt", 32'(credit_cnt), 32'd8);
    check("t2_credit_err", 32'(credit_err), 32'h0);

    // T3 wormhole lock on input 1 (rr_ptr now 1)
    bus_if.flit_type = 8'hF3;
    #1;
    check("t3_head_grant", 32'(bus_if.grant), 32'h2);
    tick();
    bus_if.flit_type = 8'hF7;
    #1;
    check("t3_body_grant",  32'(bus_if.grant), 32'h2);
    check("t3_body_locked", 32'(locked), 32'h1);
    check("t3_owner",       32'(owner), 32'h1);
    tick();
    bus_if.flit_type = 8'hFB;
    #1;
    check("t3_tail_grant",  32'(bus_if.grant), 32'h2);
    check("t3_tail_locked", 32'(locked), 32'h1);
    tick();
    bus_if.flit_type = 8'hFF;
    #1;
    check("t3_next_grant", 32'(bus_if.grant), 32'h4);
    check("t3_unlocked",   32'(locked), 32'h0);
    tick();

    // T4 drain all 8 credits, then return one
    bus_if.credit_inc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t4_grant",  32'(bus_if.grant), 32'(exp_t4[i]));
      check("t4_credit", 32'(credit_cnt), 32'(8 - i));
      tick();
    end
    check("t4_credit_zero", 32'(credit_cnt), 32'd0);
    check("t4_grant_zero",  32'(bus_if.grant), 32'h0);
    bus_if.credit_inc = 1'b1;
    #1;
    check("t4_inc_cycle_grant", 32'(bus_if.grant), 32'h0);
    tick();
    bus_if.credit_inc = 1'b0;
    #1;
    check("t4_credit_one",  32'(credit_cnt), 32'd1);
    check("t4_extra_grant", 32'(bus_if.grant), 32'h8);
    tick();
    check("t4_grant_after", 32'(bus_if.grant), 32'h0);

    // T5 simultaneous inc/dec at 3, then overflow at 8
    bus_if.req        = 4'h0;
    bus_if.credit_inc = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("t5_credit_three", 32'(credit_cnt), 32'd3);
    bus_if.req = 4'hF;
    #1;
    check("t5_grant", 32'(bus_if.grant), 32'h1);
    tick();
    check("t5_credit_hold", 32'(credit_cnt), 32'd3);
    bus_if.req = 4'h0;
    for (int i = 0; i < 5; i++) tick();
    check("t5_credit_full", 32'(credit_cnt), 32'd8);
    check("t5_err_clear",   32'(credit_err), 32'h0);
    tick();
    check("t5_err_set",      32'(credit_err), 32'h1);
    check("t5_credit_sat",   32'(credit_cnt), 32'd8);
    bus_if.credit_inc = 1'b0;

    // T6 reset while input 2 holds the lock
    bus_if.req       = 4'h4;
    bus_if.flit_type = 8'hCF;
    #1;
    check("t6_head_grant", 32'(bus_if.grant), 32'h4);
    tick();
    check("t6_locked",     32'(locked), 32'h1);
    check("t6_owner",      32'(owner), 32'h2);
    check("t6_credit_dec", 32'(credit_cnt), 32'd7);
    rst_n = 1'b0;
    #1;
    check("t6_rst_locked", 32'(locked), 32'h0);
    check("t6_rst_credit", 32'(credit_cnt), 32'd8);
    check("t6_rst_grant",  32'(bus_if.grant), 32'h0);
    check("t6_rst_err",    32'(credit_err), 32'h0);
    rst_n            = 1'b1;
    bus_if.flit_type = 8'hDF;
    #1;
    check("t6_body_grant", 32'(bus_if.grant), 32'h0);
    tick();
    check("t6_body_grant2", 32'(bus_if.grant), 32'h0);
    check("t6_idle",        32'(locked), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
